// File: rtl/pc_gen_ras.sv
// Fetch PC generator: flush, stall, RAS return, predicted target, sequential.
// Owns a circular return-address stack pushed on predicted calls.
module pc_gen_ras #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int PTGT_W = 16,
  parameter int INST_BYTES = 4,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         IF_DONE,
  input  logic                         MEM_DONE,
  input  logic                         stall,
  input  logic                         flush,
  input  logic [XLEN-1:0]              fTarget,
  input  logic                         pTaken,
  input  logic [PTGT_W-1:0]            pTarget,
  input  logic                         pCall,
  input  logic                         pRet,
  output logic [XLEN-1:0]              pc,
  output logic [1:0]                   pc_src,
  output logic [$clog2(RAS_DEPTH):0]   ras_count
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] SRC_SEQ = 2'd0;
  localparam logic [1:0] SRC_PRD = 2'd1;
  localparam logic [1:0] SRC_RAS = 2'd2;
  localparam logic [1:0] SRC_FLS = 2'd3;

  logic [XLEN-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]   top;

  logic            advance;
  logic [XLEN-1:0] seq_pc;
  logic            has_ras;
  logic [XLEN-1:0] pc_n;
  logic [1:0]      src_n;
  logic [CW-1:0]   cnt_n;
  logic [PW-1:0]   top_n;
  logic            push;

  assign advance = IF_DONE & MEM_DONE;
  assign seq_pc  = pc + XLEN'(INST_BYTES);
  assign has_ras = ras_count != '0;

  always_comb begin
    pc_n  = pc;
    src_n = pc_src;
    cnt_n = ras_count;
    top_n = top;
    push  = 1'b0;
    priority case (1'b1)
      flush: begin
        pc_n  = fTarget;
        src_n = SRC_FLS;
        cnt_n = '0;
        top_n = '0;
      end
      stall: ;
      pRet && has_ras: begin
        pc_n  = ras[top];
        src_n = SRC_RAS;
        cnt_n = ras_count - 1'b1;
        top_n = top - 1'b1;
      end
      pTaken: begin
        pc_n  = XLEN'(pTarget);
        src_n = SRC_PRD;
        // pRet here means an empty-stack return: never push
        if (pCall && !pRet) begin
          push  = 1'b1;
          top_n = top + 1'b1;
          if (ras_count != CW'(RAS_DEPTH))
            cnt_n = ras_count + 1'b1;
        end
      end
      default: begin
        pc_n  = seq_pc;
        src_n = SRC_SEQ;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_VEC;
      pc_src    <= SRC_SEQ;
      ras_count <= '0;
      top       <= '0;
      for (int i = 0; i < RAS_DEPTH; i++)
        ras[i] <= '0;
    end else if (advance) begin
      pc        <= pc_n;
      pc_src    <= src_n;
      ras_count <= cnt_n;
      top       <= top_n;
      if (push)
        ras[top_n] <= seq_pc;
    end
  end

endmodule

// File: tb/tb_pc_gen_ras.sv
// Directed vector bench for pc_gen_ras with RESET_VEC=0x100, RAS_DEPTH=4.
// Table of single-cycle vectors plus hand sequences for async reset.
module tb_pc_gen_ras;

  logic        clk = 1'b0;
  logic        rst;
  logic        IF_DONE, MEM_DONE, stall, flush;
  logic [31:0] fTarget;
  logic        pTaken;
  logic [15:0] pTarget;
  logic        pCall, pRet;
  logic [31:0] pc;
  logic [1:0]  pc_src;
  logic [2:0]  ras_count;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pc_gen_ras #(
    .XLEN(32), .RESET_VEC(32'h100), .PTGT_W(16),
    .INST_BYTES(4), .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .IF_DONE(IF_DONE), .MEM_DONE(MEM_DONE),
    .stall(stall), .flush(flush), .fTarget(fTarget),
    .pTaken(pTaken), .pTarget(pTarget), .pCall(pCall), .pRet(pRet),
    .pc(pc), .pc_src(pc_src), .ras_count(ras_count)
  );

  typedef struct {
    logic        ifd, memd, stl, fls;
    logic [31:0] ft;
    logic        pt;
    logic [15:0] ptgt;
    logic        call, ret;
    logic [31:0] epc;
    logic [1:0]  esrc;
    logic [2:0]  ecnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic ifd, memd, stl, fls,
                     input logic [31:0] ft, input logic pt,
                     input logic [15:0] ptgt, input logic call, ret,
                     input logic [31:0] epc, input logic [1:0] esrc,
                     input logic [2:0] ecnt);
    vec_t v;
    v.ifd = ifd; v.memd = memd; v.stl = stl; v.fls = fls;
    v.ft = ft; v.pt = pt; v.ptgt = ptgt; v.call = call; v.ret = ret;
    v.epc = epc; v.esrc = esrc; v.ecnt = ecnt;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic [31:0] epc,
                         input logic [1:0] esrc, input logic [2:0] ecnt);
    chk("pc", idx, pc, epc);
    chk("pc_src", idx, 32'(pc_src), 32'(esrc));
    chk("ras_count", idx, 32'(ras_count), 32'(ecnt));
  endtask

  task automatic idle();
    IF_DONE = 0; MEM_DONE = 0; stall = 0; flush = 0; fTarget = '0;
    pTaken = 0; pTarget = '0; pCall = 0; pRet = 0;
  endtask

  initial begin
    // ifd memd stl fls ft pt ptgt call ret | pc src cnt
    add(1,1,0,0,0,0,0,0,0,            32'h104,0,0);
    add(1,1,0,0,0,0,0,0,0,            32'h108,0,0);
    add(1,1,0,0,0,0,0,0,0,            32'h10C,0,0);
    add(1,1,0,1,32'h200,0,0,0,0,      32'h200,3,0);
    add(1,1,0,0,0,1,16'h3000,1,0,     32'h3000,1,1);
    add(1,1,0,0,0,0,0,0,0,            32'h3004,0,1);
    add(1,1,0,0,0,0,0,0,0,            32'h3008,0,1);
    add(1,1,0,0,0,0,0,0,1,            32'h204,2,0);
    add(1,1,0,1,32'h10,0,0,0,0,       32'h10,3,0);
    add(1,1,0,0,0,1,16'h20,1,0,       32'h20,1,1);
    add(1,1,0,0,0,1,16'h30,1,0,       32'h30,1,2);
    add(1,1,0,0,0,1,16'h40,1,0,       32'h40,1,3);
    add(1,1,0,0,0,1,16'h50,1,0,       32'h50,1,4);
    add(1,1,0,0,0,1,16'h1000,1,0,     32'h1000,1,4);
    add(1,1,0,0,0,0,0,0,1,            32'h54,2,3);
    add(1,1,0,0,0,0,0,0,1,            32'h44,2,2);
    add(1,1,0,0,0,0,0,0,1,            32'h34,2,1);
    add(1,1,0,0,0,0,0,0,1,            32'h24,2,0);
    add(1,1,0,0,0,0,0,1,1,            32'h28,0,0);
    add(1,1,0,0,0,1,16'h500,1,1,      32'h500,1,0);
    add(1,1,0,0,0,1,16'h600,1,0,      32'h600,1,1);
    add(1,1,0,0,0,1,16'h700,1,1,      32'h504,2,0);
    add(1,1,0,0,0,1,16'h900,1,0,      32'h900,1,1);
    add(1,1,1,0,0,0,0,0,1,            32'h900,1,1);
    add(1,0,1,1,32'hDEAD,1,16'h77,1,1, 32'h900,1,1);
    add(0,1,0,1,32'hBEEF,1,16'h88,1,0, 32'h900,1,1);
    add(1,1,1,1,32'h8000,1,16'h99,1,1, 32'h8000,3,0);
    add(1,1,0,0,0,0,0,1,0,            32'h8004,0,0);
    add(1,1,0,1,32'hFFFFFFFC,0,0,0,0, 32'hFFFFFFFC,3,0);
    add(1,1,0,0,0,0,0,0,0,            32'h0,0,0);

    idle();
    rst = 1;
    #12;
    chk_all(-1, 32'h100, 0, 0);
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      IF_DONE = vq[i].ifd; MEM_DONE = vq[i].memd;
      stall = vq[i].stl; flush = vq[i].fls; fTarget = vq[i].ft;
      pTaken = vq[i].pt; pTarget = vq[i].ptgt;
      pCall = vq[i].call; pRet = vq[i].ret;
      @(posedge clk);
      #1;
      chk_all(i, vq[i].epc, vq[i].esrc, vq[i].ecnt);
    end

    // push a call at 0x0, then reset mid-cycle before any edge
    @(negedge clk);
    idle();
    IF_DONE = 1; MEM_DONE = 1; pTaken = 1; pCall = 1; pTarget = 16'h40;
    @(posedge clk);
    #1;
    chk_all(100, 32'h40, 1, 1);
    @(negedge clk);
    idle();
    #2;
    rst = 1;
    #1;
    chk_all(101, 32'h100, 0, 0);
    #1;
    rst = 0;

    // stack must be empty after reset: return falls through to sequential
    @(negedge clk);
    IF_DONE = 1; MEM_DONE = 1; pRet = 1;
    @(posedge clk);
    #1;
    chk_all(102, 32'h104, 0, 0);
    @(negedge clk);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
